fft8_frame_ctrl: RTL and testbench
==================================

Name: fft8_frame_ctrl

Overview:
Frame sequencer for the 8-point radix-2 FFT datapath of three registered butterfly stages. It collects 8 complex samples from a serial stream into a bit-reversed buffer and launches them as one parallel frame into stage 1. It waits the pipeline latency, captures the 8 parallel results and streams them out in natural order with valid/ready handshaking. One frame is in flight at a time.

Parameters:
WIDTH, 16, bit width of each real/imag component (signed, two's complement)
PIPE_LAT, 3, datapath latency in clock edges from launch to valid result (one per stage); legal range >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input sample valid
in_ready  output  1  controller can accept an input sample
in_re  input  WIDTH  input sample real part
in_im  input  WIDTH  input sample imag part
fft_x_re  output  8*WIDTH  parallel frame to stage 1, real; slot k at bits [WIDTH*k+WIDTH-1 : WIDTH*k]
fft_x_im  output  8*WIDTH  parallel frame to stage 1, imag; same packing
fft_launch  output  1  one-cycle pulse marking the cycle fft_x_* is first presented
fft_y_re  input  8*WIDTH  parallel result from final stage, real; slot k = X[k]
fft_y_im  input  8*WIDTH  parallel result, imag
out_valid  output  1  output sample valid
out_ready  input  1  downstream accepts output sample
out_re  output  WIDTH  output sample real part
out_im  output  WIDTH  output sample imag part
out_idx  output  3  frequency bin index of current output sample
out_last  output  1  high with bin 7
busy  output  1  high in any state other than LOAD
frame_cnt  output  16  completed-frame counter, wraps at 2^16

Behaviour:
- Reset: state=LOAD, load index=0, out index=0. in_ready=1 after reset releases. fft_launch, out_valid, out_last, busy=0. fft_x_*, out_re/im, out_idx, frame_cnt=0. Result buffer cleared.
- Load order: input sample n (n = 0..7 in order of acceptance) is written to slot bitrev3(n). Slot order 0..7 therefore holds x0,x4,x2,x6,x1,x5,x3,x7, so adjacent slot pairs feed stage-1 butterflies.
- LOAD: in_ready=1. Each in_valid&in_ready cycle writes one sample and increments the load index. Acceptance of sample 7 -> LAUNCH next cycle, and the load index wraps to 0.
- LAUNCH: lasts 1 cycle. fft_launch=1 and in_ready=0. fft_x_* are driven from the buffer register and hold stable until the next LAUNCH. Next state is WAIT, with the wait counter loaded to PIPE_LAT-1.
- WAIT: lasts PIPE_LAT cycles, decrementing the counter. On the edge ending the cycle where the counter is 0 (launch cycle + PIPE_LAT), fft_y_* are captured into the result buffer, then the state moves to UNLOAD.
- UNLOAD: out_valid=1. out_re/im are taken from result slot out_idx, and out_last=(out_idx==7).
  - Output data is stable while out_valid&~out_ready.
  - On out_valid&out_ready, out_idx increments.
  - The handshake on bin 7 returns to LOAD, increments frame_cnt, and resets out_idx to 0.
- in_ready=0 in LAUNCH/WAIT/UNLOAD. Samples presented then are not consumed and must be held by the source.
- Timing: 8th input accepted at cycle t -> fft_launch in cycle t+1 -> first out_valid in cycle t+2+PIPE_LAT. The earliest next-frame input is the cycle after the bin-7 handshake.
- Throughput with no stalls: 8 + 1 + PIPE_LAT + 8 cycles per frame.
- No arithmetic in this block. Data passes through bit-exact and width is unchanged.
- Reset asserted in any state aborts the frame immediately and all outputs go to reset values. A partial frame is discarded, not resumed.
- in_valid asserted with rst high is ignored.

Test Plan:
- Ordering with delay-line stub (fft_y = fft_x delayed PIPE_LAT edges): input re=10..17, im=-1..-8 -> output re sequence 10,14,12,16,11,15,13,17 and im -1,-5,-3,-7,-2,-6,-4,-8; out_idx 0..7; out_last only on the 8th output; frame_cnt=1.
- Latency with PIPE_LAT=3, no stalls: 8th sample accepted at cycle 20 -> fft_launch only in cycle 21, capture at end of cycle 24, out_valid first in cycle 25. A full frame takes 20 cycles in total.
- Backpressure: out_ready=0 for 5 cycles at bin 3 -> out_re/out_im/out_idx held constant, no skipped or repeated bins. During that time in_ready stays 0 even with in_valid=1, and no input is consumed.
- Input gaps: in_valid toggled 1,0,0,1,... across the frame -> exactly 8 accepted samples, a single fft_launch, and ordering identical to the first test.
- Reset mid-WAIT: rst pulsed 2 cycles after fft_launch -> out_valid never asserts, frame_cnt=0, in_ready=1 after release. A fresh frame of 8 samples then produces correct results.
- Real datapath, impulse: x0=(1000,0), others 0 -> all 8 output bins equal (1000,0); back-to-back second frame of constant (100,0) -> bin 0 = (800,0), bins 1..7 = (0,0); frame_cnt=2.

Source files
------------

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for an 8-point radix-2 FFT pipeline: serial load into a
// bit-reversed buffer, parallel launch, latency wait, capture, serial unload.
module fft8_frame_ctrl #(
    parameter int WIDTH    = 16,
    parameter int PIPE_LAT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_re,
    input  logic [WIDTH-1:0]   in_im,
    output logic [8*WIDTH-1:0] fft_x_re,
    output logic [8*WIDTH-1:0] fft_x_im,
    output logic               fft_launch,
    input  logic [8*WIDTH-1:0] fft_y_re,
    input  logic [8*WIDTH-1:0] fft_y_im,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_re,
    output logic [WIDTH-1:0]   out_im,
    output logic [2:0]         out_idx,
    output logic               out_last,
    output logic               busy,
    output logic [15:0]        frame_cnt
);

    localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_UNLOAD = 2'd3
    } state_t;

    state_t             state_q;
    logic [2:0]         ld_idx_q;
    logic [CW-1:0]      wait_q;
    logic [8*WIDTH-1:0] buf_re_q, buf_im_q;
    logic [8*WIDTH-1:0] buf_re_d, buf_im_d;
    logic [8*WIDTH-1:0] x_re_q, x_im_q;
    logic [8*WIDTH-1:0] y_re_q, y_im_q;
    logic [2:0]         out_idx_q;
    logic [15:0]        frame_cnt_q;
    logic               in_ready_q, launch_q, out_valid_q, busy_q;
    logic [2:0]         slot;
    logic               accept;

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    assign accept = in_ready_q & in_valid;
    assign slot   = bitrev3(ld_idx_q);

    // Buffer image including the sample being accepted this cycle, so the
    // eighth sample can be launched without an extra cycle.
    always_comb begin
        buf_re_d = buf_re_q;
        buf_im_d = buf_im_q;
        buf_re_d[int'(slot)*WIDTH +: WIDTH] = in_re;
        buf_im_d[int'(slot)*WIDTH +: WIDTH] = in_im;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD;
            ld_idx_q    <= '0;
            wait_q      <= '0;
            buf_re_q    <= '0;
            buf_im_q    <= '0;
            x_re_q      <= '0;
            x_im_q      <= '0;
            y_re_q      <= '0;
            y_im_q      <= '0;
            out_idx_q   <= '0;
            frame_cnt_q <= '0;
            in_ready_q  <= 1'b1;
            launch_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        buf_re_q <= buf_re_d;
                        buf_im_q <= buf_im_d;
                        ld_idx_q <= ld_idx_q + 3'd1;
                        if (ld_idx_q == 3'd7) begin
                            x_re_q     <= buf_re_d;
                            x_im_q     <= buf_im_d;
                            state_q    <= S_LAUNCH;
                            in_ready_q <= 1'b0;
                            launch_q   <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    launch_q <= 1'b0;
                    wait_q   <= CW'(PIPE_LAT - 1);
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    // Counter reaching zero marks launch cycle + PIPE_LAT.
                    if (wait_q == '0) begin
                        y_re_q      <= fft_y_re;
                        y_im_q      <= fft_y_im;
                        state_q     <= S_UNLOAD;
                        out_valid_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q - CW'(1);
                    end
                end
                S_UNLOAD: begin
                    if (out_ready) begin
                        if (out_idx_q == 3'd7) begin
                            out_idx_q   <= '0;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            state_q     <= S_LOAD;
                        end else begin
                            out_idx_q <= out_idx_q + 3'd1;
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign fft_x_re   = x_re_q;
    assign fft_x_im   = x_im_q;
    assign fft_launch = launch_q;
    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_last   = out_valid_q & (out_idx_q == 3'd7);
    assign out_re     = out_valid_q ? y_re_q[int'(out_idx_q)*WIDTH +: WIDTH] : '0;
    assign out_im     = out_valid_q ? y_im_q[int'(out_idx_q)*WIDTH +: WIDTH] : '0;
    assign busy       = busy_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Bench for fft8_frame_ctrl: delay-line or exact-DFT stub behind the
// controller, table-driven frames, hand-written corner cases, random traffic.
module tb_fft8_frame_ctrl;
    localparam int W  = 16;
    localparam int PL = 3;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_ready, fft_launch, out_valid, out_ready = 1'b0;
    logic out_last, busy;
    logic [W-1:0] in_re = '0, in_im = '0, out_re, out_im;
    logic [8*W-1:0] fft_x_re, fft_x_im, fft_y_re, fft_y_im;
    logic [2:0] out_idx;
    logic [15:0] frame_cnt;
    bit mode = 1'b0;    // 0: delay line, 1: exact DFT
    bit chk_en = 1'b0;

    fft8_frame_ctrl #(.WIDTH(W), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .fft_x_re(fft_x_re), .fft_x_im(fft_x_im),
        .fft_launch(fft_launch), .fft_y_re(fft_y_re), .fft_y_im(fft_y_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic int brv(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    function automatic real tw_c(input int m);
        case (m)
            0: return 1.0;
            1, 7: return 0.7071067811865476;
            2, 6: return 0.0;
            4: return -1.0;
            default: return -0.7071067811865476;
        endcase
    endfunction

    function automatic real tw_s(input int m);
        case (m)
            0, 4: return 0.0;
            1, 3: return 0.7071067811865476;
            2: return 1.0;
            6: return -1.0;
            default: return -0.7071067811865476;
        endcase
    endfunction

    // X[k] = sum_n x[n] e^{-j 2 pi k n / 8}; the frame arrives in bit-reversed slots.
    function automatic logic [8*W-1:0] dft(input logic [8*W-1:0] xr, input logic [8*W-1:0] xi,
                                           input bit want_im);
        logic [8*W-1:0] res;
        real ar, ai, r, i;
        int m;
        res = '0;
        for (int k = 0; k < 8; k++) begin
            ar = 0.0; ai = 0.0;
            for (int n = 0; n < 8; n++) begin
                m = (k * n) % 8;
                r = real'($signed(xr[brv(n)*W +: W]));
                i = real'($signed(xi[brv(n)*W +: W]));
                ar = ar + r * tw_c(m) + i * tw_s(m);
                ai = ai + i * tw_c(m) - r * tw_s(m);
            end
            if (want_im) res[k*W +: W] = W'($rtoi(ai + ((ai >= 0.0) ? 0.5 : -0.5)));
            else         res[k*W +: W] = W'($rtoi(ar + ((ar >= 0.0) ? 0.5 : -0.5)));
        end
        return res;
    endfunction

    logic [8*W-1:0] dl_re [0:PL-1];
    logic [8*W-1:0] dl_im [0:PL-1];
    always @(posedge clk) begin
        dl_re[0] <= fft_x_re;
        dl_im[0] <= fft_x_im;
        for (int i = 1; i < PL; i++) begin
            dl_re[i] <= dl_re[i-1];
            dl_im[i] <= dl_im[i-1];
        end
    end
    assign fft_y_re = mode ? dft(dl_re[PL-1], dl_im[PL-1], 1'b0) : dl_re[PL-1];
    assign fft_y_im = mode ? dft(dl_re[PL-1], dl_im[PL-1], 1'b1) : dl_im[PL-1];

    int total = 0, bad = 0;
    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int src_re[$], src_im[$], part_re[$], part_im[$], exp_re[$], exp_im[$];
    int obs_re[$], obs_im[$], obs_idx[$], obs_last[$];
    int launches = 0, accepts = 0, ov_cnt = 0;
    int f_acc = 0, l_acc = 0, l_launch = 0, f_ov = 0, l_hs = 0;
    bit ov_prev = 1'b0;

    // Reference model: each completed group of 8 accepted samples is expected
    // back in bit-reversed index order (delay-line stub).
    always @(negedge clk) begin
        if (rst) begin
            part_re.delete(); part_im.delete(); exp_re.delete(); exp_im.delete();
            ov_prev = 1'b0;
        end else begin
            if (fft_launch) begin launches++; l_launch = cyc; end
            if (in_valid && in_ready) begin
                accepts++;
                if (part_re.size() == 0) f_acc = cyc;
                part_re.push_back(int'($signed(in_re)));
                part_im.push_back(int'($signed(in_im)));
                if (src_re.size() > 0) begin
                    void'(src_re.pop_front()); void'(src_im.pop_front());
                end
                if (part_re.size() == 8) begin
                    l_acc = cyc;
                    for (int k = 0; k < 8; k++) begin
                        exp_re.push_back(part_re[brv(k)]);
                        exp_im.push_back(part_im[brv(k)]);
                    end
                    part_re.delete(); part_im.delete();
                end
            end
            if (out_valid && !ov_prev) f_ov = cyc;
            ov_prev = out_valid;
            if (out_valid) ov_cnt++;
            if (out_valid && out_ready) begin
                obs_re.push_back(int'($signed(out_re)));
                obs_im.push_back(int'($signed(out_im)));
                obs_idx.push_back(int'(out_idx));
                obs_last.push_back(int'(out_last));
                if (out_last) l_hs = cyc;
                if (exp_re.size() == 0) begin
                    if (chk_en) chk("mdl_extra_output", 1, 0);
                end else begin
                    int er, ei;
                    er = exp_re.pop_front();
                    ei = exp_im.pop_front();
                    if (chk_en) begin
                        chk("mdl_re", int'($signed(out_re)), er);
                        chk("mdl_im", int'($signed(out_im)), ei);
                    end
                end
            end
        end
    end

    int phase = 0;
    task automatic step(input int gapmode, input int rdymode);
        bit g;
        case (gapmode)
            0: g = 1'b1;
            1: g = (phase % 3 == 0);
            default: g = bit'($urandom_range(0, 1));
        endcase
        phase++;
        in_valid = g && (src_re.size() > 0);
        if (src_re.size() > 0) begin
            in_re = W'(src_re[0]);
            in_im = W'(src_im[0]);
        end
        out_ready = (rdymode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive(input int target, input int gapmode, input int rdymode, input string nm);
        int n;
        n = 0;
        phase = 0;
        while (1) begin
            @(posedge clk); #1;
            if (obs_re.size() >= target) break;
            if (n >= 4000) begin
                chk({nm, "_timeout"}, obs_re.size(), target);
                break;
            end
            step(gapmode, rdymode);
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic clr_obs();
        obs_re.delete(); obs_im.delete(); obs_idx.delete(); obs_last.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        src_re.delete(); src_im.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clr_obs();
    endtask

    task automatic push_frame(input int re[8], input int im[8]);
        for (int k = 0; k < 8; k++) begin
            src_re.push_back(re[k]);
            src_im.push_back(im[k]);
        end
    endtask

    typedef struct {
        bit dft;
        bit rst_first;
        int fc;
        int ire[8]; int iim[8];
        int ere[8]; int eim[8];
    } vec_t;
    vec_t tbl[4];

    initial begin
        int a0, l0, ov0;
        int fr[8], fi[8];

        tbl[0].dft = 0; tbl[0].rst_first = 0; tbl[0].fc = 1;
        tbl[0].ire = '{10, 11, 12, 13, 14, 15, 16, 17};
        tbl[0].iim = '{-1, -2, -3, -4, -5, -6, -7, -8};
        tbl[0].ere = '{10, 14, 12, 16, 11, 15, 13, 17};
        tbl[0].eim = '{-1, -5, -3, -7, -2, -6, -4, -8};
        tbl[1].dft = 0; tbl[1].rst_first = 0; tbl[1].fc = 2;
        tbl[1].ire = '{32767, -32768, 0, -1, 1, 32766, -32767, 12345};
        tbl[1].iim = '{-32768, 32767, -1, 0, 100, -100, 2, -2};
        tbl[1].ere = '{32767, 1, 0, -32767, -32768, 32766, -1, 12345};
        tbl[1].eim = '{-32768, 100, -1, 2, 32767, -100, 0, -2};
        tbl[2].dft = 1; tbl[2].rst_first = 1; tbl[2].fc = 1;
        tbl[2].ire = '{1000, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].iim = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].ere = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
        tbl[2].eim = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].dft = 1; tbl[3].rst_first = 0; tbl[3].fc = 2;
        tbl[3].ire = '{100, 100, 100, 100, 100, 100, 100, 100};
        tbl[3].iim = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].ere = '{800, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].eim = '{0, 0, 0, 0, 0, 0, 0, 0};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_launch", fft_launch, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_fft_x", (fft_x_re == '0 && fft_x_im == '0), 1);
        chk("rst_out_idx", out_idx, 0);

        // Table-driven frames
        for (int t = 0; t < 4; t++) begin
            if (tbl[t].rst_first) do_reset();
            mode = tbl[t].dft;
            chk_en = 1'b0;
            clr_obs();
            push_frame(tbl[t].ire, tbl[t].iim);
            drive(8, 0, 0, "tbl");
            for (int k = 0; k < 8; k++) begin
                if (k < obs_re.size()) begin
                    chk($sformatf("tbl%0d_re%0d", t, k), obs_re[k], tbl[t].ere[k]);
                    chk($sformatf("tbl%0d_im%0d", t, k), obs_im[k], tbl[t].eim[k]);
                    chk($sformatf("tbl%0d_idx%0d", t, k), obs_idx[k], k);
                    chk($sformatf("tbl%0d_last%0d", t, k), obs_last[k], (k == 7) ? 1 : 0);
                end
            end
            @(negedge clk);
            chk($sformatf("tbl%0d_frame_cnt", t), frame_cnt, tbl[t].fc);
        end
        mode = 1'b0;

        // Latency, no stalls
        do_reset();
        chk_en = 1'b1;
        l0 = launches;
        for (int k = 0; k < 8; k++) begin fr[k] = 30 + k; fi[k] = -30 - k; end
        push_frame(fr, fi);
        drive(8, 0, 0, "lat");
        chk("lat_launch_after_acc", l_launch - l_acc, 1);
        chk("lat_first_valid", f_ov - l_acc, 2 + PL);
        chk("lat_frame_len", l_hs - f_acc + 1, 20);
        chk("lat_launch_cnt", launches - l0, 1);
        chk("lat_x_slot1", int'($signed(fft_x_re[1*W +: W])), 34);
        chk("lat_x_slot6", int'($signed(fft_x_im[6*W +: W])), -33);
        chk("lat_launch_low", fft_launch, 0);

        // Backpressure for 5 cycles at bin 3
        clr_obs();
        for (int k = 0; k < 8; k++) begin fr[k] = 20 + k; fi[k] = -20 - k; end
        push_frame(fr, fi);
        drive(3, 0, 0, "bp_a");
        out_ready = 1'b0;
        in_valid = 1'b1; in_re = W'(999); in_im = W'(-999);
        a0 = accepts;
        repeat (5) begin
            @(negedge clk);
            chk("bp_idx", out_idx, 3);
            chk("bp_re", int'($signed(out_re)), 26);
            chk("bp_im", int'($signed(out_im)), -26);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_no_accept", accepts - a0, 0);
        drive(8, 0, 0, "bp_b");
        for (int k = 0; k < 8 && k < obs_idx.size(); k++) chk("bp_idx_seq", obs_idx[k], k);

        // Input gaps 1,0,0,...
        clr_obs();
        a0 = accepts; l0 = launches;
        push_frame(tbl[0].ire, tbl[0].iim);
        drive(8, 1, 0, "gap");
        chk("gap_accepts", accepts - a0, 8);
        chk("gap_launches", launches - l0, 1);
        for (int k = 0; k < 8 && k < obs_re.size(); k++) chk("gap_re", obs_re[k], tbl[0].ere[k]);

        // Reset two cycles after launch
        clr_obs();
        l0 = launches;
        push_frame(tbl[0].ire, tbl[0].iim);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (launches > l0) break;
            step(0, 0);
        end
        in_valid = 1'b0;
        chk("rw_launch_seen", launches - l0, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        ov0 = ov_cnt;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        src_re.delete(); src_im.delete();
        repeat (10) @(posedge clk);
        #1;
        chk("rw_no_out_valid", ov_cnt - ov0, 0);
        chk("rw_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        chk("rw_in_ready", in_ready, 1);
        clr_obs();
        push_frame(tbl[0].ire, tbl[0].iim);
        drive(8, 0, 0, "rw_fresh");
        for (int k = 0; k < 8 && k < obs_re.size(); k++) begin
            chk("rw_re", obs_re[k], tbl[0].ere[k]);
            chk("rw_im", obs_im[k], tbl[0].eim[k]);
        end
        @(negedge clk);
        chk("rw_frame_cnt_after", frame_cnt, 1);

        // Random traffic against the model
        do_reset();
        chk_en = 1'b1;
        l0 = launches;
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 8; k++) begin
                fr[k] = int'($signed(W'($urandom)));
                fi[k] = int'($signed(W'($urandom)));
            end
            push_frame(fr, fi);
        end
        drive(48, 2, 1, "rnd");
        @(negedge clk);
        chk("rnd_frame_cnt", frame_cnt, 6);
        chk("rnd_model_drained", exp_re.size(), 0);
        chk("rnd_launches", launches - l0, 6);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
